// File: rtl/buzzer_pkg.sv
// Shared types and tone constants for the buzzer sequencer slice.
package buzzer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TONE = 2'd1,
    GAP  = 2'd2
  } state_e;

  localparam logic [16:0] HP_TONE_LOW  = 17'd95_419;
  localparam logic [16:0] HP_TONE_MID  = 17'd50_607;
  localparam logic [16:0] HP_TONE_HIGH = 17'd20_000;

  // Lowest set bit index; returns 0 when nothing is set.
  function automatic logic [2:0] first_set(input logic [7:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) idx = 3'(i);
      else      idx = idx;
    end
    return idx;
  endfunction

endpackage

// File: rtl/buzzer_sequencer_tone_divider.sv
// Square-wave generator: output toggles each time the counter reaches the half-period.
module tone_divider
  import buzzer_pkg::*;
#(
  parameter int HP_W = 17
) (
  input  logic            CLK,
  input  logic            RSTn,
  input  logic            enable,
  input  logic            clear,
  input  logic [HP_W-1:0] half_period,
  output logic            wave
);

  logic [HP_W-1:0] cnt_q, cnt_d;
  logic            wave_q, wave_d;

  // Clear wins over enable so a new tone always starts low from a zero count.
  always_comb begin
    cnt_d  = cnt_q;
    wave_d = wave_q;
    if (clear) begin
      cnt_d  = '0;
      wave_d = 1'b0;
    end else if (enable) begin
      if (cnt_q == half_period) begin
        cnt_d  = '0;
        wave_d = ~wave_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Divider state register.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      cnt_q  <= '0;
      wave_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      wave_q <= wave_d;
    end
  end

  assign wave = wave_q;

endmodule

// File: rtl/buzzer_sequencer.sv
// Prioritised multi-channel beep sequencer: edge-triggered requests, tone/gap
// timing, pre-emption by higher-priority channels and synchronous stop.
module buzzer_sequencer
  import buzzer_pkg::*;
#(
  parameter int N_CH    = 4,
  parameter int HP_W    = 17,
  parameter int ON_CYC  = 5_000_000,
  parameter int GAP_CYC = 2_500_000
) (
  input  logic                 CLK,
  input  logic                 RSTn,
  input  logic [N_CH-1:0]      req,
  input  logic [N_CH*HP_W-1:0] half_period,
  input  logic [N_CH*4-1:0]    repeat_cnt,
  input  logic                 stop,
  output logic                 Buzzer_Out,
  output logic                 busy,
  output logic [2:0]           active_ch,
  output logic                 done
);

  localparam int ON_W  = (ON_CYC  > 1) ? $clog2(ON_CYC)  : 1;
  localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  state_e          state_q, state_d;
  logic [N_CH-1:0] req_q, pending_q, pending_d, rise, clr_mask;
  logic [2:0]      active_q, active_d, gnt_idx;
  logic [HP_W-1:0] hp_q, hp_d;
  logic [3:0]      rep_q, rep_d, beep_q, beep_d, rep_in;
  logic [ON_W-1:0] on_q, on_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic            done_q, done_d, buzz_q, buzz_d;
  logic            any_pend, preempt, grant, div_en, div_clr, wave;

  tone_divider #(.HP_W(HP_W)) u_div (
    .CLK         (CLK),
    .RSTn        (RSTn),
    .enable      (div_en),
    .clear       (div_clr),
    .half_period (hp_q),
    .wave        (wave)
  );

  // Request edge detection, arbitration, sequencing and output selection.
  always_comb begin
    rise     = req & ~req_q;
    any_pend = |pending_q;
    gnt_idx  = first_set(8'(pending_q));
    preempt  = any_pend && (gnt_idx < active_q) && (state_q != IDLE);
    for (int i = 0; i < N_CH; i++) clr_mask[i] = (3'(i) == gnt_idx);
    rep_in   = repeat_cnt[gnt_idx*4 +: 4];

    state_d   = state_q;
    pending_d = pending_q | rise;
    active_d  = active_q;
    hp_d      = hp_q;
    rep_d     = rep_q;
    beep_d    = beep_q;
    on_d      = on_q;
    gap_d     = gap_q;
    done_d    = 1'b0;
    grant     = 1'b0;
    div_en    = 1'b0;
    div_clr   = 1'b0;

    if (stop) begin
      state_d   = IDLE;
      pending_d = '0;
      active_d  = 3'd0;
      beep_d    = 4'd0;
      on_d      = '0;
      gap_d     = '0;
    end else begin
      case (state_q)
        IDLE: grant = any_pend;
        TONE: begin
          if (preempt) begin
            grant = 1'b1;
          end else begin
            div_en = 1'b1;
            if (on_q == ON_W'(ON_CYC - 1)) begin
              on_d = '0;
              if (beep_q < rep_q) begin
                state_d = GAP;
                beep_d  = beep_q + 4'd1;
              end else begin
                state_d  = IDLE;
                done_d   = 1'b1;
                active_d = 3'd0;
                beep_d   = 4'd0;
              end
            end else begin
              on_d = on_q + 1'b1;
            end
          end
        end
        GAP: begin
          if (preempt) begin
            grant = 1'b1;
          end else if (gap_q == GAP_W'(GAP_CYC - 1)) begin
            gap_d   = '0;
            state_d = TONE;
            div_clr = 1'b1;
          end else begin
            gap_d = gap_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase

      if (grant) begin
        state_d   = TONE;
        pending_d = (pending_q & ~clr_mask) | rise;
        active_d  = gnt_idx;
        hp_d      = half_period[gnt_idx*HP_W +: HP_W];
        rep_d     = (rep_in == 4'd0) ? 4'd0 : rep_in - 4'd1;
        beep_d    = 4'd0;
        on_d      = '0;
        gap_d     = '0;
        div_clr   = 1'b1;
      end else begin
        div_clr = div_clr;
      end
    end

    // Forcing silence on stop/pre-empt makes the abort audible on the same edge.
    buzz_d = (state_q == TONE && !stop && !preempt) ? wave : 1'b1;
  end

  // Sequencer state and registered outputs.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q   <= IDLE;
      req_q     <= '0;
      pending_q <= '0;
      active_q  <= 3'd0;
      hp_q      <= '0;
      rep_q     <= 4'd0;
      beep_q    <= 4'd0;
      on_q      <= '0;
      gap_q     <= '0;
      done_q    <= 1'b0;
      buzz_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      req_q     <= req;
      pending_q <= pending_d;
      active_q  <= active_d;
      hp_q      <= hp_d;
      rep_q     <= rep_d;
      beep_q    <= beep_d;
      on_q      <= on_d;
      gap_q     <= gap_d;
      done_q    <= done_d;
      buzz_q    <= buzz_d;
    end
  end

  assign Buzzer_Out = buzz_q;
  assign busy       = (state_q != IDLE);
  assign active_ch  = active_q;
  assign done       = done_q;

endmodule

// File: tb/tb_buzzer_sequencer.sv
// Directed bench for buzzer_sequencer with short beep/gap timing.
module tb_buzzer_sequencer;

  localparam int N_CH = 4, HP_W = 17, ON_CYC = 20, GAP_CYC = 10;

  logic                 CLK = 1'b0;
  logic                 RSTn = 1'b0;
  logic [N_CH-1:0]      req = '0;
  logic [N_CH*HP_W-1:0] half_period = '0;
  logic [N_CH*4-1:0]    repeat_cnt = '0;
  logic                 stop = 1'b0;
  logic                 Buzzer_Out, busy, done;
  logic [2:0]           active_ch;

  int checks = 0;
  int failures = 0;
  int n_done, n_busy, n_low;
  logic exp_b;

  always #5 CLK = ~CLK;

  buzzer_sequencer #(.N_CH(N_CH), .HP_W(HP_W), .ON_CYC(ON_CYC), .GAP_CYC(GAP_CYC)) dut (
    .CLK(CLK), .RSTn(RSTn), .req(req), .half_period(half_period), .repeat_cnt(repeat_cnt),
    .stop(stop), .Buzzer_Out(Buzzer_Out), .busy(busy), .active_ch(active_ch), .done(done)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input int observed, input int expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d t=%0t", tag, observed, expected, $time);
    end
  endtask

  task automatic set_ch(input int ch, input int hp, input int rep);
    half_period[ch*HP_W +: HP_W] = HP_W'(hp);
    repeat_cnt[ch*4 +: 4] = 4'(rep);
  endtask

  function automatic logic wave_at(input int k, input int hp);
    return ((k / (hp + 1)) % 2) == 1;
  endfunction

  initial begin
    // Reset state
    repeat (3) tick();
    chk("rst_buzz", Buzzer_Out, 1);
    chk("rst_busy", busy, 0);
    chk("rst_active", active_ch, 0);
    chk("rst_done", done, 0);
    RSTn = 1'b1;
    tick();
    chk("post_rst_busy", busy, 0);

    // Channel 2: hp=3, two beeps with a gap
    set_ch(2, 3, 2);
    req = 4'b0100;
    tick();
    chk("c2_e0_busy", busy, 0);
    tick();
    chk("c2_e1_busy", busy, 1);
    chk("c2_e1_active", active_ch, 2);
    chk("c2_e1_buzz", Buzzer_Out, 1);
    for (int c = 0; c < 50; c++) begin
      tick();
      exp_b = (c < 20) ? wave_at(c, 3) : (c < 30) ? 1'b1 : wave_at(c - 30, 3);
      chk("c2_buzz", Buzzer_Out, int'(exp_b));
      chk("c2_done", done, int'(c == 49));
      chk("c2_busy", busy, int'(c != 49));
    end
    tick();
    chk("c2_end_buzz", Buzzer_Out, 1);
    chk("c2_end_done", done, 0);

    // Channel 0: hp=0, rep=0 -> one beep toggling every cycle
    req = '0;
    set_ch(0, 0, 0);
    tick();
    req = 4'b0001;
    tick();
    tick();
    chk("c0_active", active_ch, 0);
    chk("c0_busy", busy, 1);
    for (int c = 0; c < 20; c++) begin
      tick();
      chk("c0_buzz", Buzzer_Out, c % 2);
      chk("c0_done", done, int'(c == 19));
      chk("c0_busy_run", busy, int'(c != 19));
    end
    tick();
    chk("c0_end_buzz", Buzzer_Out, 1);
    chk("c0_end_done", done, 0);

    // Simultaneous req[1] and req[3]
    req = '0;
    set_ch(1, 1, 1);
    set_ch(3, 2, 1);
    tick();
    req = 4'b1010;
    tick();
    tick();
    chk("sim_first_active", active_ch, 1);
    n_done = 0;
    for (int c = 0; c < 45; c++) begin
      tick();
      if (c < 20)       exp_b = wave_at(c, 1);
      else if (c == 20) exp_b = 1'b1;
      else if (c <= 40) exp_b = wave_at(c - 21, 2);
      else              exp_b = 1'b1;
      chk("sim_buzz", Buzzer_Out, int'(exp_b));
      chk("sim_busy", busy, int'((c < 19) || (c >= 20 && c < 40)));
      chk("sim_done", done, int'(c == 19 || c == 40));
      if (c == 0)  chk("sim_active_1", active_ch, 1);
      if (c == 20) chk("sim_active_3", active_ch, 3);
      n_done += int'(done);
    end
    chk("sim_done_count", n_done, 2);

    // Channel 3 pre-empted by channel 0
    req = '0;
    set_ch(3, 2, 3);
    set_ch(0, 0, 0);
    tick();
    req = 4'b1000;
    tick();
    tick();
    chk("pre_active3", active_ch, 3);
    repeat (5) tick();
    req = 4'b1001;
    tick();
    chk("pre_still3", active_ch, 3);
    tick();
    chk("pre_active0", active_ch, 0);
    chk("pre_busy", busy, 1);
    chk("pre_buzz_quiet", Buzzer_Out, 1);
    chk("pre_no_done", done, 0);
    for (int c = 0; c < 20; c++) begin
      tick();
      chk("pre_c0_buzz", Buzzer_Out, c % 2);
      chk("pre_c0_done", done, int'(c == 19));
    end
    n_busy = 0;
    n_done = 0;
    repeat (40) begin
      tick();
      n_busy += int'(busy);
      n_done += int'(done);
    end
    chk("pre_no_replay", n_busy, 0);
    chk("pre_no_extra_done", n_done, 0);

    // Stop during GAP with req[1] pending
    req = '0;
    set_ch(0, 1, 2);
    set_ch(1, 1, 1);
    tick();
    req = 4'b0001;
    tick();
    tick();
    chk("stop_active", active_ch, 0);
    repeat (4) tick();
    req = 4'b0011;
    repeat (18) tick();
    chk("stop_gap_busy", busy, 1);
    chk("stop_gap_buzz", Buzzer_Out, 1);
    chk("stop_gap_active", active_ch, 0);
    stop = 1'b1;
    tick();
    chk("stop_busy", busy, 0);
    chk("stop_buzz", Buzzer_Out, 1);
    chk("stop_done", done, 0);
    chk("stop_active0", active_ch, 0);
    stop = 1'b0;
    req = '0;
    n_busy = 0;
    n_low = 0;
    repeat (40) begin
      tick();
      n_busy += int'(busy);
      n_low  += int'(!Buzzer_Out);
    end
    chk("stop_no_busy", n_busy, 0);
    chk("stop_silent", n_low, 0);

    // Reset in the middle of a beep with another channel pending
    set_ch(2, 3, 2);
    set_ch(3, 0, 0);
    req = 4'b1100;
    tick();
    tick();
    chk("rmid_active", active_ch, 2);
    repeat (3) tick();
    chk("rmid_tone", Buzzer_Out, 0);
    #2;
    RSTn = 1'b0;
    #1;
    chk("rmid_buzz", Buzzer_Out, 1);
    chk("rmid_busy", busy, 0);
    chk("rmid_active0", active_ch, 0);
    chk("rmid_done", done, 0);
    req = '0;
    tick();
    tick();
    RSTn = 1'b1;
    n_busy = 0;
    n_low = 0;
    repeat (40) begin
      tick();
      n_busy += int'(busy);
      n_low  += int'(!Buzzer_Out);
    end
    chk("rmid_no_busy", n_busy, 0);
    chk("rmid_silent", n_low, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
